// File: rtl/full_top.sv
// full_top: two-button tug-of-war game on a 7-LED bar.
// Each button is synchronized, debounced and turned into move requests
// (one on press, then one every REPEAT_CYCLES while held). A ten-state
// FSM walks a single lit LED toward the requester until a side wins.
// Optional feature macro: WIN_BLINK_EN (blinks the win pattern every
// BLINK_CYCLES cycles; when undefined the win pattern is steady).
module full_top #(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned REPEAT_CYCLES = 64,
    parameter int unsigned BLINK_CYCLES  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pbl,
    input  logic       pbr,
    output logic [6:0] leds_out
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

    // Parameter sanity: every cycle count must be at least one.
    if (DEB_CYCLES < 1 || REPEAT_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
        $error("full_top: DEB_CYCLES, REPEAT_CYCLES and BLINK_CYCLES must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, L3, L2, L1, N, R1, R2, R3, LWIN, RWIN
    } state_t;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [DEB_W-1:0] deb_cnt [2];
    logic [REP_W-1:0] rep_cnt [2];

    logic [1:0] rise_c;
    logic [1:0] hit_c;
    logic       both_c;
    logic       req_l_c;
    logic       req_r_c;

    state_t state;

    // Display pattern for each state.
    function automatic logic [6:0] led_pattern(input state_t s);
        case (s)
            L3:      return 7'b1000000;
            L2:      return 7'b0100000;
            L1:      return 7'b0010000;
            N:       return 7'b0001000;
            R1:      return 7'b0000100;
            R2:      return 7'b0000010;
            R3:      return 7'b0000001;
            LWIN:    return 7'b1110000;
            RWIN:    return 7'b0000111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Move rules; IDLE behaves like the centre position, wins are sticky.
    function automatic state_t next_state(input state_t s, input logic l, input logic r);
        state_t ns;
        ns = s;
        case (s)
            IDLE, N: ns = l ? L1   : (r ? R1   : s);
            L1:      ns = l ? L2   : (r ? N    : s);
            L2:      ns = l ? L3   : (r ? L1   : s);
            L3:      ns = l ? LWIN : (r ? L1   : s);
            R1:      ns = l ? N    : (r ? R2   : s);
            R2:      ns = l ? R1   : (r ? R3   : s);
            R3:      ns = l ? R1   : (r ? RWIN : s);
            LWIN, RWIN: ns = s;
            default: ns = IDLE;
        endcase
        return ns;
    endfunction

    // Press edges, repeat ticks and simultaneous-press lockout.
    always_comb begin
        rise_c = deb & ~deb_q;
        both_c = &deb;
        hit_c  = '0;
        for (int i = 0; i < 2; i++) begin
            hit_c[i] = deb[i] && (rep_cnt[i] == REP_W'(REPEAT_CYCLES - 1));
        end
        req_l_c = !both_c && (rise_c[0] || hit_c[0]);
        req_r_c = !both_c && (rise_c[1] || hit_c[1]);
    end

    // Synchronizers, debouncers and auto-repeat counters for both buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
                rep_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {pbr, pbl};
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end

                if (!deb[i] || both_c || rise_c[i] || hit_c[i]) begin
                    rep_cnt[i] <= '0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
                end
            end
        end
    end

`ifdef WIN_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    // Game FSM with registered display; win patterns blink.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            leds_out  <= '0;
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            state <= next_state(state, req_l_c, req_r_c);
            if (state == LWIN || state == RWIN) begin
                leds_out <= blink_off ? 7'b0000000 : led_pattern(state);
                if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end else begin
                leds_out  <= led_pattern(state);
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end
        end
    end
`else
    // Game FSM with registered display, one cycle behind the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            leds_out <= '0;
        end else begin
            state    <= next_state(state, req_l_c, req_r_c);
            leds_out <= led_pattern(state);
        end
    end
`endif

endmodule

// File: tb/tb_full_top.sv
// Bench for full_top: expected LED changes are queued as stimulus is
// applied and compared (value and repeat spacing) as the display changes.
module tb_full_top;

    localparam int unsigned DEB   = 4;
    localparam int unsigned REP   = 16;
    localparam int unsigned BLINK = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pbl = 1'b0;
    logic       pbr = 1'b0;
    logic [6:0] leds_out;

    full_top #(
        .DEB_CYCLES   (DEB),
        .REPEAT_CYCLES(REP),
        .BLINK_CYCLES (BLINK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pbl     (pbl),
        .pbr     (pbr),
        .leds_out(leds_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] leds;
        int         gap;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         last_cyc  = 0;
    logic [6:0] prev_leds = '0;
    bit         mon_en    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_led(input string tag, input logic [6:0] v, input int gap);
        exp_t e;
        e.tag  = tag;
        e.leds = v;
        e.gap  = gap;
        sb_q.push_back(e);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Every display change must match the next queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && leds_out !== prev_leds) begin
            if (sb_q.size() == 0) begin
                check("unexpected_led", 32'(leds_out), 32'(prev_leds));
            end else begin
                e = sb_q.pop_front();
                check(e.tag, 32'(leds_out), 32'(e.leds));
                if (e.gap != 0) check({e.tag, "_gap"}, 32'(cyc - last_cyc), 32'(e.gap));
            end
            prev_leds = leds_out;
            last_cyc  = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    task automatic do_reset(input int n);
        if (leds_out !== 7'b0000000) expect_led("rst_clear", 7'b0000000, 0);
        rst = 1'b1;
        #1;
        check("async_rst", 32'(leds_out), 32'd0);
        tick(n);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Long reset, then idle with no buttons.
        tick(5);
        check("rst_leds", 32'(leds_out), 32'd0);
        tick(95);
        mon_en = 1'b1;
        rst    = 1'b0;
        tick(60);
        check("idle_hold", 32'(leds_out), 32'd0);

        // Hold right from IDLE through to a right win.
        pbr = 1'b1;
        expect_led("r_r1", 7'b0000100, 0);
        expect_led("r_r2", 7'b0000010, REP);
        expect_led("r_r3", 7'b0000001, REP);
        expect_led("r_win", 7'b0000111, REP);
        wait_drain("hold_r", 6 * REP + 30);
        tick(3 * REP);
        check("rwin_hold", 32'(leds_out), 32'(7'b0000111));
        pbr = 1'b0;
        tick(10);
        do_reset(5);

        // Walk to R3, then hold left: catch-up and on to a left win.
        pbr = 1'b1;
        expect_led("w_r1", 7'b0000100, 0);
        expect_led("w_r2", 7'b0000010, REP);
        expect_led("w_r3", 7'b0000001, REP);
        wait_drain("walk_r3", 4 * REP + 30);
        pbr = 1'b0;
        tick(12);
        pbl = 1'b1;
        expect_led("cu_r1", 7'b0000100, 0);
        expect_led("l_n", 7'b0001000, REP);
        expect_led("l_l1", 7'b0010000, REP);
        expect_led("l_l2", 7'b0100000, REP);
        expect_led("l_l3", 7'b1000000, REP);
        expect_led("l_win", 7'b1110000, REP);
        wait_drain("hold_l", 7 * REP + 30);
        tick(2 * REP);
`ifdef WIN_BLINK_EN
        expect_led("blink_off", 7'b0000000, BLINK);
        expect_led("blink_on", 7'b1110000, BLINK);
        wait_drain("blink", 3 * BLINK);
`else
        check("lwin_hold", 32'(leds_out), 32'(7'b1110000));
`endif
        pbl = 1'b0;
        tick(10);
        do_reset(5);

        // Fresh game after a win: pulse right, then hold left.
        pbr = 1'b1;
        tick(8);
        pbr = 1'b0;
        expect_led("p_r1", 7'b0000100, 0);
        wait_drain("pulse_r", 30);
        tick(10);
        pbl = 1'b1;
        expect_led("h_n", 7'b0001000, 0);
        expect_led("h_l1", 7'b0010000, REP);
        expect_led("h_l2", 7'b0100000, REP);
        wait_drain("hold_l2", 3 * REP + 30);

        // Reset mid-repeat at L2 with left still held through release.
        tick(REP / 2);
        do_reset(5);
        tick(3);
        check("no_move_release", 32'(leds_out), 32'd0);
        expect_led("held_l1", 7'b0010000, 0);
        wait_drain("held_press", 30);
        pbl = 1'b0;
        tick(10);

        // Back to N, then both buttons together and short glitches.
        pbr = 1'b1;
        tick(8);
        pbr = 1'b0;
        expect_led("back_n", 7'b0001000, 0);
        wait_drain("to_n", 30);
        tick(10);
        pbl = 1'b1;
        pbr = 1'b1;
        tick(3 * REP);
        check("both_hold", 32'(leds_out), 32'(7'b0001000));
        pbl = 1'b0;
        pbr = 1'b0;
        tick(10);
        pbl = 1'b1;
        tick(2);
        pbl = 1'b0;
        tick(20);
        pbr = 1'b1;
        tick(DEB - 1);
        pbr = 1'b0;
        tick(20);
        check("glitch", 32'(leds_out), 32'(7'b0001000));
        pbl = 1'b1;
        tick(8);
        pbl = 1'b0;
        expect_led("after_glitch_l1", 7'b0010000, 0);
        wait_drain("after_glitch", 30);

        tick(5);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/full_top.md
FULL_TOP -- requirements
Module: full_top

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4: consecutive identical synchronized samples needed to accept a button level change.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 64: clock cycles between auto-repeat moves while a button stays held.
REQ-003 SHALL have parameter BLINK_CYCLES, default 256: half-period of the win blink, used only with WIN_BLINK_EN.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port pbl, input, 1 bit: left player push button, active-high, asynchronous to clk.
REQ-007 SHALL have port pbr, input, 1 bit: right player push button, active-high, asynchronous to clk.
REQ-008 SHALL have port leds_out, output, 7 bits: registered display; bit 6 is the leftmost LED.

Function
REQ-009 SHALL pass pbl and pbr each through a 2-flop synchronizer followed by a debouncer of DEB_CYCLES.
REQ-010 SHALL generate a move request on the cycle a debounced button rises, then every REPEAT_CYCLES cycles while it stays high.
REQ-011 SHALL ignore a move request when both debounced buttons are high in the same cycle, and restart both repeat counters.
REQ-012 SHALL implement states IDLE, L3, L2, L1, N, R1, R2, R3, LWIN, RWIN.
REQ-013 SHALL drive leds_out per state: IDLE 0000000, L3 1000000, L2 0100000, L1 0010000, N 0001000, R1 0000100, R2 0000010, R3 0000001, LWIN 1110000, RWIN 0000111.
REQ-014 SHALL treat IDLE as position N for move purposes: pbr goes to R1, pbl goes to L1.
REQ-015 SHALL move one position toward the requester per request: pbl moves left, pbr moves right.
REQ-016 SHALL apply the catch-up rule from R3: pbl goes to R1 (two steps); from L3, pbr goes to L1.
REQ-017 SHALL go from L3 to LWIN on pbl, and from R3 to RWIN on pbr.
REQ-018 SHALL hold LWIN and RWIN, ignoring all buttons, until reset.
REQ-019 SHALL update leds_out on the clock edge after the state change, giving one cycle of latency from move request to LED change.

Reset
REQ-020 SHALL, while rst is high, asynchronously force state IDLE, leds_out 0000000, and clear synchronizers, debouncers, repeat and blink counters.
REQ-021 SHALL, after rst falls, remain in IDLE until the first accepted move request.
REQ-022 SHALL let an assertion during play or a win abort immediately to IDLE, with no move applied on the release cycle.
REQ-023 SHALL treat a button already held at reset release as a new press once debounced.

Configuration
REQ-024 SHALL compile the WIN_BLINK_EN macro feature as follows.
- Defined: in LWIN/RWIN, leds_out alternates between the win pattern and 0000000 every BLINK_CYCLES cycles, starting with the pattern.
- Undefined: the win pattern is shown steadily and the blink counter is absent.

Verification
REQ-025 SHALL pass this scenario: rst high 100 cycles, then low, no buttons -> leds_out 0000000 indefinitely.
REQ-026 SHALL pass this scenario: from IDLE, hold pbr -> leds_out steps 0000100, 0000010, 0000001, then 0000111, REPEAT_CYCLES apart; it then stays 0000111 with pbr held.
REQ-027 SHALL pass this scenario: at R3, hold pbl -> 0000100 (catch-up), then 0001000, 0010000, 0100000, 1000000, 1110000.
REQ-028 SHALL pass this scenario: in LWIN, assert rst then release; pulse pbr -> 0000100; hold pbl -> 0001000, then 0010000.
REQ-029 SHALL pass this scenario: pbl and pbr high together from N -> leds_out unchanged; a glitch shorter than DEB_CYCLES -> no move.
REQ-030 SHALL pass this scenario: rst pulse mid-repeat at L2 -> leds_out 0000000 asynchronously; with WIN_BLINK_EN defined, LWIN toggles 1110000/0000000 every 256 cycles.
